arrival_predictor: RTL

ARRIVAL_PREDICTOR -- requirements
Module: arrival_predictor

---
 rtl/arrival_predictor.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/arrival_predictor.sv
// arrival_predictor
//   Predicts the arrival time at a target point from the transit time
//   measured between two sensors:
//     time_out = floor(T * DIST_PRED / DIST_MEAS) - OFFSET_MS, clamped to
//     [0, 2^TW-1].
//   The multiply takes one cycle. A restoring divider then produces one
//   quotient bit per cycle over PW cycles.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  / in_ready / time_in    sample input handshake (ms)
//   out_valid / out_ready / time_out  result output handshake (ms)
//   sat       result was clamped (low or high)
//   err       sample was zero; time_out forced to 0
//
// Build option
//   ARRIVAL_PREDICTOR_AVG_EN : T is the mean of the last 4 accepted non-zero
//   samples instead of the raw sample.
module arrival_predictor #(
  parameter int TW        = 19,
  parameter int DIST_MEAS = 41,
  parameter int DIST_PRED = 666,
  parameter int OFFSET_MS = 30
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [TW-1:0] time_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [TW-1:0] time_out,
  output logic          sat,
  output logic          err
);

  localparam int PW = TW + $clog2(DIST_PRED + 1);
  localparam int CW = $clog2(PW + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [PW:0] DIVISOR = (PW+1)'(DIST_MEAS);
  localparam logic [PW:0] OFFSET  = (PW+1)'(OFFSET_MS);
  localparam logic [PW:0] MAXVAL  = {{(PW+1-TW){1'b0}}, {TW{1'b1}}};

  logic [1:0]    state;
  logic [TW-1:0] t_reg;
  logic [TW-1:0] t_eff;
  logic [PW-1:0] prod;
  logic [PW-1:0] quo;
  logic [PW:0]   rem;
  logic [CW-1:0] cnt;

  logic [PW:0]   rem_sh;
  logic          q_bit;
  logic [PW:0]   rem_nx;
  logic [PW-1:0] quo_nx;
  logic [PW:0]   q_ext;
  logic [PW:0]   diff;
  logic [TW-1:0] res;
  logic          res_sat;

  logic accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

`ifdef ARRIVAL_PREDICTOR_AVG_EN
  logic [TW-1:0] hist [4];
  logic          filled;
  logic [TW+1:0] sum;

  always_comb begin
    sum   = (TW+2)'(hist[0]) + (TW+2)'(hist[1]) + (TW+2)'(hist[2]) + (TW+2)'(hist[3]);
    t_eff = TW'(sum >> 2);
  end

  // Zero samples never enter the history; the first real sample after
  // reset seeds all four slots so the mean starts at that value.
  always_ff @(posedge clk) begin
    if (rst) begin
      filled <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) hist[i] <= '0;
    end else if (accept && (time_in != '0)) begin
      if (!filled) begin
        filled <= 1'b1;
        for (int unsigned i = 0; i < 4; i++) hist[i] <= time_in;
      end else begin
        hist[3] <= hist[2];
        hist[2] <= hist[1];
        hist[1] <= hist[0];
        hist[0] <= time_in;
      end
    end
  end
`else
  assign t_eff = t_reg;
`endif

  assign prod = PW'(t_eff) * PW'(DIST_PRED);

  // One restoring-division step; quo shifts the dividend out of its top
  // while quotient bits enter at the bottom.
  always_comb begin
    rem_sh = {rem[PW-1:0], quo[PW-1]};
    q_bit  = (rem_sh >= DIVISOR);
    rem_nx = q_bit ? (rem_sh - DIVISOR) : rem_sh;
    quo_nx = {quo[PW-2:0], q_bit};
  end

  // Offset and clamp are applied to the quotient completed by the final step.
  always_comb begin
    q_ext   = {1'b0, quo_nx};
    diff    = '0;
    res     = '0;
    res_sat = 1'b0;
    if (q_ext < OFFSET) begin
      res_sat = 1'b1;
    end else begin
      diff = q_ext - OFFSET;
      if (diff > MAXVAL) begin
        res     = '1;
        res_sat = 1'b1;
      end else begin
        res = diff[TW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      t_reg    <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      time_out <= '0;
      sat      <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            t_reg <= time_in;
            state <= MUL;
          end
        end
        MUL: begin
          if (t_reg == '0) begin
            time_out <= '0;
            sat      <= 1'b0;
            err      <= 1'b1;
            state    <= DONE;
          end else begin
            quo   <= prod;
            rem   <= '0;
            cnt   <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          quo <= quo_nx;
          rem <= rem_nx;
          if (cnt == CW'(PW - 1)) begin
            time_out <= res;
            sat      <= res_sat;
            err      <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule
